// File: rtl/img_pkg.sv
// Shared image-pipeline defaults and small elaboration-time helpers.
package img_pkg;
  localparam int IMG_W    = 128;
  localparam int PIX_W    = 8;
  localparam int WIN_TAPS = 3;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  // Never returns zero, so single-entry ranges still get a 1-bit vector.
  function automatic int width_of(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

  // base and inc are both below modulus, so one subtraction is enough.
  function automatic int wrap_add(input int base, input int inc, input int modulus);
    int sum;
    sum = base + inc;
    if (sum >= modulus) sum = sum - modulus;
    return sum;
  endfunction
endpackage

// File: rtl/lb_tap_mem.sv
// Pixel storage: one write port and TAPS asynchronous read ports that
// return consecutive entries from raddr, wrapping modulo DEPTH.
module lb_tap_mem
  import img_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int DEPTH  = IMG_W,
  parameter int TAPS   = WIN_TAPS,
  localparam int AW    = width_of(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [AW-1:0]          raddr,
  output logic [TAPS*DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     tap_addr [TAPS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Tap 0 is the oldest pixel and lands in the most significant slot.
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    assign tap_addr[k] = AW'(wrap_add(int'(raddr), k, DEPTH));
    assign rdata[(TAPS-k)*DATA_W-1 -: DATA_W] = mem[tap_addr[k]];
  end

endmodule

// File: rtl/line_window_buffer.sv
// Line window buffer: stores incoming pixels and presents a sliding TAPS-wide
// window that steps one pixel at a time and skips to the next line at its end.
module line_window_buffer
  import img_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int LINE_W = IMG_W,
  parameter int DEPTH  = IMG_W,
  parameter int TAPS   = WIN_TAPS,
  localparam int COL_W = width_of(LINE_W),
  localparam int CNT_W = width_of(DEPTH + 1),
  localparam int AW    = width_of(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [TAPS*DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   rd_advance,
  output logic [COL_W-1:0]       out_col,
  output logic                   line_done,
  output logic [CNT_W-1:0]       count,
  output logic                   overflow_err
);

  if (TAPS < 1 || TAPS > LINE_W || LINE_W > DEPTH) begin : g_bad_params
    $error("line_window_buffer: need 1 <= TAPS <= LINE_W <= DEPTH");
  end

  // Handshake: a pixel moves when in_valid && in_ready; a window is taken
  // when rd_advance && out_valid. Neither ready depends on the other side.
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             adv_acc;
  logic             last_win;
  int               pop;
  logic [CNT_W-1:0] count_next;
  logic [COL_W-1:0] col_next;

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count >= CNT_W'(TAPS));
  assign wr_acc    = in_valid && in_ready;
  assign adv_acc   = rd_advance && out_valid;
  assign last_win  = (out_col == COL_W'(LINE_W - TAPS));

  always_comb begin
    pop      = 0;
    col_next = out_col;
    if (adv_acc) begin
      if (last_win) begin
        pop      = TAPS;
        col_next = '0;
      end else begin
        pop      = 1;
        col_next = out_col + COL_W'(1);
      end
    end
    count_next = count + CNT_W'(wr_acc) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_col      <= '0;
      line_done    <= 1'b0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_col   <= '0;
      line_done <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= AW'(wrap_add(int'(wr_ptr), 1, DEPTH));
      if (adv_acc) rd_ptr <= AW'(wrap_add(int'(rd_ptr), pop, DEPTH));
      count     <= count_next;
      out_col   <= col_next;
      line_done <= adv_acc && last_win;
      if (in_valid && !in_ready) overflow_err <= 1'b1;
    end
  end

  // Flush and reset win over a same-cycle write, so the memory stays untouched.
  lb_tap_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .TAPS  (TAPS)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc && !flush && !reset),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(out_data)
  );

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_line_window_buffer;
  localparam int DATA_W = 8;
  localparam int LINE_W = 6;
  localparam int DEPTH  = 8;
  localparam int TAPS   = 3;

  logic                   clk;
  logic                   reset;
  logic                   flush;
  logic [DATA_W-1:0]      in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [TAPS*DATA_W-1:0] out_data;
  logic                   out_valid;
  logic                   rd_advance;
  logic [2:0]             out_col;
  logic                   line_done;
  logic [3:0]             count;
  logic                   overflow_err;

  line_window_buffer #(
    .DATA_W(DATA_W), .LINE_W(LINE_W), .DEPTH(DEPTH), .TAPS(TAPS)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .rd_advance(rd_advance), .out_col(out_col),
    .line_done(line_done), .count(count), .overflow_err(overflow_err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: stored pixels oldest-first, window column, flags
  logic [DATA_W-1:0] exp_q[$];
  int m_col;
  bit m_done;
  bit m_ovf;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input logic [DATA_W-1:0] d,
                            input bit a, input bit f, input bit r);
    bit full;
    bit has_win;
    if (r) begin
      exp_q.delete(); m_col = 0; m_done = 0; m_ovf = 0;
    end else if (f) begin
      exp_q.delete(); m_col = 0; m_done = 0;
    end else begin
      full    = (exp_q.size() >= DEPTH);
      has_win = (exp_q.size() >= TAPS);
      m_done  = 0;
      if (a && has_win) begin
        if (m_col == LINE_W - TAPS) begin
          for (int i = 0; i < TAPS; i++) void'(exp_q.pop_front());
          m_col  = 0;
          m_done = 1;
        end else begin
          void'(exp_q.pop_front());
          m_col++;
        end
      end
      if (v) begin
        if (!full) exp_q.push_back(d);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic model_check();
    chk("count", count, exp_q.size());
    chk("in_ready", in_ready, exp_q.size() < DEPTH);
    chk("out_valid", out_valid, exp_q.size() >= TAPS);
    chk("out_col", out_col, m_col);
    chk("line_done", line_done, m_done);
    chk("overflow_err", overflow_err, m_ovf);
    if (exp_q.size() >= TAPS)
      chk("out_data", out_data, {exp_q[0], exp_q[1], exp_q[2]});
  endtask

  // driver: inputs change on the falling edge, outputs are checked there too
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d,
                       input bit a, input bit f, input bit r);
    in_valid = v; in_data = d; rd_advance = a; flush = f; reset = r;
    @(posedge clk);
    model_step(v, d, a, f, r);
    @(negedge clk);
    in_valid = 0; rd_advance = 0; flush = 0; reset = 0;
    model_check();
  endtask

  typedef struct {
    bit                     v;
    logic [DATA_W-1:0]      d;
    bit                     a;
    int                     cnt;
    bit                     ov;
    logic [TAPS*DATA_W-1:0] dat;
    int                     col;
    bit                     done;
  } vec_t;

  vec_t tbl[17];

  initial begin
    in_valid = 0; in_data = '0; rd_advance = 0; flush = 0; reset = 1;

    // expected results after each cycle: write 0..5, walk the line, wrap line 2
    tbl[0]  = '{1, 8'h00, 0, 1, 0, 24'h0,      0, 0};
    tbl[1]  = '{1, 8'h01, 0, 2, 0, 24'h0,      0, 0};
    tbl[2]  = '{1, 8'h02, 0, 3, 1, 24'h000102, 0, 0};
    tbl[3]  = '{1, 8'h03, 0, 4, 1, 24'h000102, 0, 0};
    tbl[4]  = '{1, 8'h04, 0, 5, 1, 24'h000102, 0, 0};
    tbl[5]  = '{1, 8'h05, 0, 6, 1, 24'h000102, 0, 0};
    tbl[6]  = '{0, 8'h00, 1, 5, 1, 24'h010203, 1, 0};
    tbl[7]  = '{0, 8'h00, 1, 4, 1, 24'h020304, 2, 0};
    tbl[8]  = '{0, 8'h00, 1, 3, 1, 24'h030405, 3, 0};
    tbl[9]  = '{0, 8'h00, 1, 0, 0, 24'h0,      0, 1};
    tbl[10] = '{0, 8'h00, 0, 0, 0, 24'h0,      0, 0};
    tbl[11] = '{1, 8'h10, 0, 1, 0, 24'h0,      0, 0};
    tbl[12] = '{1, 8'h11, 0, 2, 0, 24'h0,      0, 0};
    tbl[13] = '{1, 8'h12, 0, 3, 1, 24'h101112, 0, 0};
    tbl[14] = '{1, 8'h13, 0, 4, 1, 24'h101112, 0, 0};
    tbl[15] = '{1, 8'h14, 0, 5, 1, 24'h101112, 0, 0};
    tbl[16] = '{1, 8'h15, 0, 6, 1, 24'h101112, 0, 0};

    @(negedge clk);
    cycle(0, 8'h00, 0, 0, 1);
    cycle(1, 8'h55, 1, 1, 1);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_count", count, 0);

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].a, 0, 0);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_col", i), out_col, tbl[i].col);
      chk($sformatf("tbl%0d_done", i), line_done, tbl[i].done);
      if (tbl[i].ov) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].dat);
    end
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, 0);
    chk("line2_done", line_done, 1);

    // fill to DEPTH, then a dropped write
    cycle(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'h20 + 8'(i), 0, 0, 0);
    chk("full_in_ready", in_ready, 0);
    cycle(1, 8'hAA, 0, 0, 0);
    chk("ovf_set", overflow_err, 1);
    chk("ovf_count", count, 8);
    chk("ovf_window", out_data, 24'h202122);

    // flush keeps overflow_err; then concurrent write+advance mid-line; then reset
    cycle(0, 8'h00, 0, 1, 0);
    chk("flush_ovf_kept", overflow_err, 1);
    for (int i = 0; i < 5; i++) cycle(1, 8'h30 + 8'(i), 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    chk("mid_count", count, 4);
    chk("mid_col", out_col, 1);
    cycle(1, 8'h35, 1, 0, 0);
    chk("wr_adv_count", count, 4);
    chk("wr_adv_col", out_col, 2);
    cycle(1, 8'h36, 1, 0, 1);
    chk("midreset_count", count, 0);
    chk("midreset_valid", out_valid, 0);
    chk("midreset_ovf", overflow_err, 0);
    chk("midreset_ready", in_ready, 1);

    // count=5 with overflow_err set, then flush alongside a write
    for (int i = 0; i < DEPTH + 1; i++) cycle(1, 8'h40 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0, 0);
    chk("pre_flush_count", count, 5);
    cycle(1, 8'h77, 0, 1, 0);
    chk("flush_count", count, 0);
    chk("flush_ovf", overflow_err, 1);
    for (int i = 0; i < 3; i++) cycle(1, 8'h50 + 8'(i), 0, 0, 0);
    chk("flush_no_store", out_data, 24'h505152);

    // randomized traffic against the model
    cycle(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 99) < 60, 8'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 55, $urandom_range(0, 199) == 0,
            $urandom_range(0, 299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
